// File: rtl/ram_dp_be_clr_if.sv
// Bundle of both user ports of ram_dp_be_clr plus its init/collision status.
interface ram_dp_be_clr_if #(
   parameter int ADDR_W    = 9,
   parameter int WIDTH     = 32,
   parameter int NUM_BYTES = 4
);
   logic [ADDR_W-1:0]    address_a;
   logic                 wren_a;
   logic [NUM_BYTES-1:0] byteena_a;
   logic [WIDTH-1:0]     data_a;
   logic                 rden_a;
   logic [WIDTH-1:0]     q_a;
   logic                 q_valid_a;

   logic [ADDR_W-1:0]    address_b;
   logic                 wren_b;
   logic [NUM_BYTES-1:0] byteena_b;
   logic [WIDTH-1:0]     data_b;
   logic                 rden_b;
   logic [WIDTH-1:0]     q_b;
   logic                 q_valid_b;

   logic                 init_busy;
   logic                 collision;

   modport master (
      output address_a, wren_a, byteena_a, data_a, rden_a,
      output address_b, wren_b, byteena_b, data_b, rden_b,
      input  q_a, q_valid_a, q_b, q_valid_b, init_busy, collision
   );

   modport slave (
      input  address_a, wren_a, byteena_a, data_a, rden_a,
      input  address_b, wren_b, byteena_b, data_b, rden_b,
      output q_a, q_valid_a, q_b, q_valid_b, init_busy, collision
   );
endinterface

// File: rtl/ram_dp_be_clr.sv
// True dual-port RAM with byte enables, selectable read-during-write, optional
// output register, write-write collision flag and a post-reset clear sequencer.
module ram_dp_be_clr #(
   parameter int               DEPTH          = 512,
   parameter int               WIDTH          = 32,
   parameter int               BYTE_WIDTH     = 8,
   parameter bit               RDW_NEW        = 1'b0,
   parameter bit               OUT_REG        = 1'b0,
   parameter bit               CLEAR_ON_RESET = 1'b1,
   parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0
) (
   input logic            clock,
   input logic            reset,
   ram_dp_be_clr_if.slave bus
);
   localparam int NUM_BYTES = WIDTH / BYTE_WIDTH;
   localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t            state;
   logic [ADDR_W-1:0] clr_ptr;
   logic              init_busy;
   logic              collision_q;
   logic [WIDTH-1:0]  mem [DEPTH];

   logic              idle;
   logic              in_range_a, in_range_b;
   logic              wr_a, wr_b, rd_a, rd_b, collide;
   logic [WIDTH-1:0]  old_a, old_b, rdata_a, rdata_b;

   logic [WIDTH-1:0]  q_a_p0, q_b_p0, q_a_p1, q_b_p1;
   logic              vld_a_p0, vld_b_p0, vld_a_p1, vld_b_p1;

   function automatic logic [WIDTH-1:0] byte_merge(
      input logic [WIDTH-1:0]     old_word,
      input logic [WIDTH-1:0]     new_word,
      input logic [NUM_BYTES-1:0] lanes
   );
      logic [WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < NUM_BYTES; i++)
         if (lanes[i])
            merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      return merged;
   endfunction

   assign idle       = (state == ST_IDLE);
   assign in_range_a = ({1'b0, bus.address_a} < DEPTH_W);
   assign in_range_b = ({1'b0, bus.address_b} < DEPTH_W);

   assign wr_a = idle && bus.wren_a && in_range_a;
   assign wr_b = idle && bus.wren_b && in_range_b;
   assign rd_a = idle && bus.rden_a;
   assign rd_b = idle && bus.rden_b;

   // Out-of-range reads complete normally but return zero.
   assign old_a = in_range_a ? mem[bus.address_a] : '0;
   assign old_b = in_range_b ? mem[bus.address_b] : '0;

   assign rdata_a = (RDW_NEW && wr_a) ? byte_merge(old_a, bus.data_a, bus.byteena_a) : old_a;
   assign rdata_b = (RDW_NEW && wr_b) ? byte_merge(old_b, bus.data_b, bus.byteena_b) : old_b;

   assign collide = wr_a && wr_b && (bus.address_a == bus.address_b)
                    && (|(bus.byteena_a & bus.byteena_b));

   // Storage: clear sequencer owns the array while clearing; port B wins shared lanes.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == ST_CLEAR) begin
            mem[clr_ptr] <= CLEAR_VALUE;
         end else begin
            for (int i = 0; i < NUM_BYTES; i++) begin
               if (wr_a && bus.byteena_a[i])
                  mem[bus.address_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
               if (wr_b && bus.byteena_b[i])
                  mem[bus.address_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         clr_ptr     <= '0;
         init_busy   <= CLEAR_ON_RESET;
         collision_q <= 1'b0;
      end else begin
         collision_q <= collide;
         if (state == ST_CLEAR) begin
            if (clr_ptr == LAST_ADDR) begin
               state     <= ST_IDLE;
               init_busy <= 1'b0;
               clr_ptr   <= '0;
            end else begin
               clr_ptr <= clr_ptr + 1'b1;
            end
         end
      end
   end

   // Stage p0: array read; stage p1: optional output register.
   always_ff @(posedge clock) begin
      if (reset) begin
         q_a_p0   <= '0;
         q_b_p0   <= '0;
         q_a_p1   <= '0;
         q_b_p1   <= '0;
         vld_a_p0 <= 1'b0;
         vld_b_p0 <= 1'b0;
         vld_a_p1 <= 1'b0;
         vld_b_p1 <= 1'b0;
      end else begin
         vld_a_p0 <= rd_a;
         vld_b_p0 <= rd_b;
         if (rd_a) q_a_p0 <= rdata_a;
         if (rd_b) q_b_p0 <= rdata_b;
         vld_a_p1 <= vld_a_p0;
         vld_b_p1 <= vld_b_p0;
         if (vld_a_p0) q_a_p1 <= q_a_p0;
         if (vld_b_p0) q_b_p1 <= q_b_p0;
      end
   end

   assign bus.q_a       = OUT_REG ? q_a_p1 : q_a_p0;
   assign bus.q_b       = OUT_REG ? q_b_p1 : q_b_p0;
   assign bus.q_valid_a = OUT_REG ? vld_a_p1 : vld_a_p0;
   assign bus.q_valid_b = OUT_REG ? vld_b_p1 : vld_b_p0;
   assign bus.init_busy = init_busy;
   assign bus.collision = collision_q;
endmodule

// File: tb/tb_ram_dp_be_clr.sv
// Directed bench: dut0 is DEPTH=16/old-data/latency 1, dut1 is DEPTH=12/new-data/latency 2,
// both fed identical stimulus.
module tb_ram_dp_be_clr;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   n0, n1, spur;

   localparam logic [31:0] CV = 32'hDEADBEEF;

   logic [3:0]  lat_addr [4] = '{4'd5, 4'd7, 4'd3, 4'd2};
   logic [31:0] lat_exp  [4] = '{32'h11BB33DD, 32'h12345678, 32'hBBBBAAAA, CV};

   ram_dp_be_clr_if #(.ADDR_W(4), .WIDTH(32), .NUM_BYTES(4)) bus0 ();
   ram_dp_be_clr_if #(.ADDR_W(4), .WIDTH(32), .NUM_BYTES(4)) bus1 ();

   assign bus1.address_a = bus0.address_a;
   assign bus1.wren_a    = bus0.wren_a;
   assign bus1.byteena_a = bus0.byteena_a;
   assign bus1.data_a    = bus0.data_a;
   assign bus1.rden_a    = bus0.rden_a;
   assign bus1.address_b = bus0.address_b;
   assign bus1.wren_b    = bus0.wren_b;
   assign bus1.byteena_b = bus0.byteena_b;
   assign bus1.data_b    = bus0.data_b;
   assign bus1.rden_b    = bus0.rden_b;

   ram_dp_be_clr #(.DEPTH(16), .WIDTH(32), .BYTE_WIDTH(8), .RDW_NEW(1'b0), .OUT_REG(1'b0),
                   .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV))
      dut0 (.clock(clock), .reset(reset), .bus(bus0));

   ram_dp_be_clr #(.DEPTH(12), .WIDTH(32), .BYTE_WIDTH(8), .RDW_NEW(1'b1), .OUT_REG(1'b1),
                   .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV))
      dut1 (.clock(clock), .reset(reset), .bus(bus1));

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus0.wren_a = 1'b0; bus0.rden_a = 1'b0; bus0.byteena_a = 4'h0;
      bus0.wren_b = 1'b0; bus0.rden_b = 1'b0; bus0.byteena_b = 4'h0;
   endtask

   task automatic write_a(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
      bus0.address_a = addr; bus0.data_a = data; bus0.byteena_a = be; bus0.wren_a = 1'b1;
      tick();
      idle_inputs();
   endtask

   task automatic read_b(input logic [3:0] addr, input logic [31:0] exp0, input logic [31:0] exp1);
      bus0.address_b = addr; bus0.rden_b = 1'b1;
      tick();
      idle_inputs();
      check_eq("rd0_valid", 32'(bus0.q_valid_b), 32'd1);
      check_eq("rd0_data", bus0.q_b, exp0);
      check_eq("rd1_early", 32'(bus1.q_valid_b), 32'd0);
      tick();
      check_eq("rd1_valid", 32'(bus1.q_valid_b), 32'd1);
      check_eq("rd1_data", bus1.q_b, exp1);
   endtask

   task automatic read_all();
      for (int a = 0; a < 16; a++)
         read_b(4'(a), CV, (a < 12) ? CV : 32'h0);
   endtask

   // Counts edges until each init_busy drops; optionally hammers both ports meanwhile.
   task automatic run_clear(input bit poke, output int c0, output int c1, output int bad);
      c0 = 0; c1 = 0; bad = 0;
      for (int i = 1; i <= 40; i++) begin
         if (poke && i <= 10) begin
            bus0.address_a = 4'd2; bus0.data_a = 32'h12345678; bus0.byteena_a = 4'hF;
            bus0.wren_a = 1'b1; bus0.rden_a = 1'b1;
            bus0.address_b = 4'd2; bus0.data_b = 32'h0; bus0.byteena_b = 4'hF;
            bus0.wren_b = 1'b1; bus0.rden_b = 1'b1;
         end else begin
            idle_inputs();
         end
         tick();
         if (bus0.q_valid_a || bus0.q_valid_b || bus0.collision ||
             bus1.q_valid_a || bus1.q_valid_b || bus1.collision)
            bad++;
         if (c0 == 0 && !bus0.init_busy) c0 = i;
         if (c1 == 0 && !bus1.init_busy) c1 = i;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus0.address_a = '0; bus0.data_a = '0; bus0.address_b = '0; bus0.data_b = '0;
      idle_inputs();
      reset = 1'b1;
      repeat (3) tick();
      check_eq("rst_q_a", bus0.q_a, 32'h0);
      check_eq("rst_vld_a", 32'(bus0.q_valid_a), 32'd0);
      check_eq("rst_coll", 32'(bus0.collision), 32'd0);
      check_eq("rst_busy0", 32'(bus0.init_busy), 32'd1);
      check_eq("rst_busy1", 32'(bus1.init_busy), 32'd1);
      check_eq("rst_q_b1", bus1.q_b, 32'h0);

      reset = 1'b0;
      run_clear(1'b1, n0, n1, spur);
      check_eq("clr_len0", 32'(n0), 32'd16);
      check_eq("clr_len1", 32'(n1), 32'd12);
      check_eq("clr_quiet", 32'(spur), 32'd0);
      read_all();

      write_a(4'd5, 32'h11223344, 4'hF);
      write_a(4'd5, 32'hAABBCCDD, 4'b0101);
      read_b(4'd5, 32'h11BB33DD, 32'h11BB33DD);

      write_a(4'd7, 32'h0, 4'hF);
      bus0.address_a = 4'd7; bus0.data_a = 32'h12345678; bus0.byteena_a = 4'hF;
      bus0.wren_a = 1'b1; bus0.rden_a = 1'b1;
      bus0.address_b = 4'd7; bus0.rden_b = 1'b1;
      tick();
      idle_inputs();
      check_eq("rdw_old_q_a", bus0.q_a, 32'h0);
      check_eq("rdw_old_vld", 32'(bus0.q_valid_a), 32'd1);
      check_eq("rdw_old_q_b", bus0.q_b, 32'h0);
      tick();
      check_eq("rdw_new_q_a", bus1.q_a, 32'h12345678);
      check_eq("rdw_new_q_b", bus1.q_b, 32'h0);
      read_b(4'd7, 32'h12345678, 32'h12345678);

      write_a(4'd3, 32'h0, 4'hF);
      bus0.address_a = 4'd3; bus0.data_a = 32'hAAAAAAAA; bus0.byteena_a = 4'b0011; bus0.wren_a = 1'b1;
      bus0.address_b = 4'd3; bus0.data_b = 32'hBBBBBBBB; bus0.byteena_b = 4'b0110; bus0.wren_b = 1'b1;
      tick();
      idle_inputs();
      check_eq("coll_pulse0", 32'(bus0.collision), 32'd1);
      check_eq("coll_pulse1", 32'(bus1.collision), 32'd1);
      tick();
      check_eq("coll_end0", 32'(bus0.collision), 32'd0);
      check_eq("coll_end1", 32'(bus1.collision), 32'd0);
      read_b(4'd3, 32'h00BBBBAA, 32'h00BBBBAA);

      write_a(4'd3, 32'h0, 4'hF);
      bus0.address_a = 4'd3; bus0.data_a = 32'hAAAAAAAA; bus0.byteena_a = 4'b0011; bus0.wren_a = 1'b1;
      bus0.address_b = 4'd3; bus0.data_b = 32'hBBBBBBBB; bus0.byteena_b = 4'b1100; bus0.wren_b = 1'b1;
      tick();
      idle_inputs();
      check_eq("nocoll0", 32'(bus0.collision), 32'd0);
      check_eq("nocoll1", 32'(bus1.collision), 32'd0);
      tick();
      check_eq("nocoll0_late", 32'(bus0.collision), 32'd0);
      read_b(4'd3, 32'hBBBBAAAA, 32'hBBBBAAAA);

      bus0.address_a = 4'd13; bus0.data_a = 32'h1; bus0.byteena_a = 4'hF; bus0.wren_a = 1'b1;
      bus0.address_b = 4'd13; bus0.data_b = 32'h2; bus0.byteena_b = 4'hF; bus0.wren_b = 1'b1;
      tick();
      idle_inputs();
      check_eq("oor_coll_in0", 32'(bus0.collision), 32'd1);
      check_eq("oor_coll_out1", 32'(bus1.collision), 32'd0);
      read_b(4'd13, 32'h2, 32'h0);

      bus0.address_a = 4'd5; bus0.rden_a = 1'b1;
      tick();
      idle_inputs();
      check_eq("lat_vld0", 32'(bus0.q_valid_a), 32'd1);
      check_eq("lat_q0", bus0.q_a, 32'h11BB33DD);
      check_eq("lat_vld1_n1", 32'(bus1.q_valid_a), 32'd0);
      tick();
      check_eq("lat_vld1_n2", 32'(bus1.q_valid_a), 32'd1);
      check_eq("lat_q1", bus1.q_a, 32'h11BB33DD);
      check_eq("lat_vld0_off", 32'(bus0.q_valid_a), 32'd0);
      tick();
      check_eq("lat_vld1_n3", 32'(bus1.q_valid_a), 32'd0);

      for (int i = 0; i < 4; i++) begin
         bus0.address_a = lat_addr[i]; bus0.rden_a = 1'b1;
         tick();
         check_eq("b2b_vld0", 32'(bus0.q_valid_a), 32'd1);
         check_eq("b2b_q0", bus0.q_a, lat_exp[i]);
         check_eq("b2b_vld1", 32'(bus1.q_valid_a), (i > 0) ? 32'd1 : 32'd0);
         if (i > 0) check_eq("b2b_q1", bus1.q_a, lat_exp[i-1]);
      end
      idle_inputs();
      tick();
      check_eq("b2b_tail_vld1", 32'(bus1.q_valid_a), 32'd1);
      check_eq("b2b_tail_q1", bus1.q_a, lat_exp[3]);
      check_eq("b2b_tail_vld0", 32'(bus0.q_valid_a), 32'd0);
      tick();
      check_eq("b2b_done_vld1", 32'(bus1.q_valid_a), 32'd0);

      write_a(4'd0, 32'h55555555, 4'hF);
      write_a(4'd9, 32'h55555555, 4'hF);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (8) tick();
      reset = 1'b1;
      tick();
      check_eq("rst2_q_a0", bus0.q_a, 32'h0);
      check_eq("rst2_q_a1", bus1.q_a, 32'h0);
      check_eq("rst2_busy0", 32'(bus0.init_busy), 32'd1);
      reset = 1'b0;
      run_clear(1'b0, n0, n1, spur);
      check_eq("reclr_len0", 32'(n0), 32'd16);
      check_eq("reclr_len1", 32'(n1), 32'd12);
      read_all();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ram_dp_be_clr.md
Name: ram_dp_be_clr

Overview:
- Parametrised true dual-port synchronous RAM. Next generation of the generic rwrw dual-port primitive.
- Adds per-byte write enables, a selectable same-port read-during-write mode, an optional output register stage, and read-valid flags.
- Adds cross-port write-collision detection and a hardware clear sequencer that initialises every word after reset.
- Used by cache tag/data arrays and CPU-side buffers that need known contents without a software init loop.

Parameters:
- DEPTH, 512: number of words; need not be a power of two.
- WIDTH, 32: word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits per write-enable lane. NUM_BYTES = WIDTH/BYTE_WIDTH.
- RDW_NEW, 0: same-port read-during-write. 0 = old data, 1 = new (merged) data.
- OUT_REG, 0: 1 adds a second output register, so read latency becomes 2.
- CLEAR_ON_RESET, 1: 1 runs the clear sequencer after reset.
- CLEAR_VALUE, 0: WIDTH-bit value written to every word by the clear sequencer.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- init_busy  out  1  high while the clear sequence is pending or running.
- address_a  in  ADDR_W  port A word address; ADDR_W = max(1,$clog2(DEPTH)).
- wren_a  in  1  port A write.
- byteena_a  in  NUM_BYTES  port A byte lanes to write.
- data_a  in  WIDTH  port A write data.
- rden_a  in  1  port A read.
- q_a  out  WIDTH  port A read data.
- q_valid_a  out  1  q_a updated this cycle.
- address_b, wren_b, byteena_b, data_b, rden_b, q_b, q_valid_b: identical to port A.
- collision  out  1  one-cycle pulse on a same-address write-write collision.

Behaviour:
- Reset (reset=1 at clock edge):
  - q_a, q_b <= 0; q_valid_a, q_valid_b <= 0; collision <= 0.
  - Clear pointer <= 0; FSM <= CLEAR if CLEAR_ON_RESET, else IDLE.
  - init_busy <= CLEAR_ON_RESET.
  - Memory contents are not touched while reset is held.
- FSM states:
  - CLEAR: one word written per cycle, ram[ptr] <= CLEAR_VALUE, ptr increments. When ptr == DEPTH-1 the write happens and the next state is IDLE.
  - CLEAR lasts exactly DEPTH cycles after reset deasserts. init_busy is 1 during all of them and 0 from the first IDLE cycle.
  - IDLE: normal operation.
  - reset asserted mid-CLEAR restarts the sequence from address 0.
- During CLEAR:
  - All user wren/rden are ignored; user data is not stored.
  - q_* hold their value; q_valid_* stay 0; collision stays 0.
- Write (IDLE): for each lane i with wren_x & byteena_x[i], ram[address_x][lane i] <= data_x[lane i]. Lanes with byteena=0 are unchanged.
- Read (IDLE):
  - rden_x sampled at edge N. With OUT_REG=0, q_x and q_valid_x=1 appear after edge N.
  - With OUT_REG=1 they appear one edge later; q_valid is delayed identically through the same pipeline.
  - q_x holds its last value when no read completes; q_valid_x is 1 only in completion cycles.
- Same-port read+write, same cycle:
  - RDW_NEW=0 returns pre-write contents.
  - RDW_NEW=1 returns the word after this port's byte-merge.
- Cross-port read of an address the other port writes in the same cycle: always returns old data.
- Write-write, same address, same cycle:
  - Lanes enabled on both ports take port B data.
  - Lanes enabled on one port only take that port's data.
  - collision pulses 1 on the next cycle, only if at least one lane overlaps.
- Out-of-range address (address >= DEPTH, non-power-of-2 DEPTH):
  - Writes are dropped.
  - Reads complete normally (q_valid=1) with q=0.
  - Never flags collision.
- Both ports may read the same address simultaneously with no side effects.

Test Plan:
- Clear: DEPTH=16, CLEAR_VALUE=32'hDEADBEEF, reset high 3 cycles then low.
  - Required: init_busy=1 for exactly 16 cycles, then 0.
  - Required: reading addresses 0..15 on port B all return DEADBEEF with q_valid_b=1.
  - Required: a wren_a issued during CLEAR does not change memory.
- Byte enables: write 32'h11223344 to address 5 (byteena 4'hF), then 32'hAABBCCDD with byteena 4'b0101.
  - Required: a read of address 5 returns 32'h11BB33DD.
- RDW modes: address 7 holds 32'h0; same cycle port A writes 32'h12345678 and reads address 7.
  - Required: RDW_NEW=0 gives q_a=0; RDW_NEW=1 gives q_a=12345678.
  - Required: a concurrent port B read of address 7 returns 0 in both modes.
- Collision: same cycle, A writes 32'hAAAAAAAA byteena 4'b0011 and B writes 32'hBBBBBBBB byteena 4'b0110, both to address 3.
  - Required: address 3 = 32'h00BBBBAA (starting from 0).
  - Required: collision=1 for exactly one cycle.
  - Repeat with B byteena 4'b1100. Required: no overlapping lane, so collision stays 0.
- Latency: OUT_REG=1, rden_a pulsed at cycle 10.
  - Required: q_valid_a=1 only at cycle 12, with correct data.
  - Back-to-back reads at cycles 20-23. Required: valid at 22-25 in order.
- Reset mid-clear: assert reset at clear cycle 8 of 16, release.
  - Required: init_busy stays high a full 16 cycles after release.
  - Required: all words equal CLEAR_VALUE afterwards.
